// File: rtl/fwd_hazard_unit_pkg.sv
// rtl/fwd_hazard_unit_pkg.sv - shared encodings for the forwarding/hazard unit
package fwd_hazard_unit_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam int ZERO_REG_DEF = 31;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    LOAD_WAIT = 2'd1,
    MEM_WAIT  = 2'd2
  } fsm_state_t;

endpackage

// File: rtl/fwd_hazard_unit_cmp.sv
// rtl/fwd_hazard_unit_cmp.sv - per-operand forwarding priority comparator
module fwd_operand_cmp
  import fwd_hazard_unit_pkg::*;
#(
  parameter int REG_W    = 5,
  parameter int ZERO_REG = ZERO_REG_DEF
) (
  input  logic             i_src_valid,
  input  logic [REG_W-1:0] i_src_reg,
  input  logic             i_wr_mem,
  input  logic [REG_W-1:0] i_tgt_mem,
  input  logic             i_wr_wb,
  input  logic [REG_W-1:0] i_tgt_wb,
  output logic [1:0]       o_sel
);

  localparam logic [REG_W-1:0] ZR = REG_W'(ZERO_REG);

  logic w_live;

  // A zero-register source can never match, so destinations of XZR are excluded implicitly.
  assign w_live = i_src_valid && (i_src_reg != ZR);

  always_comb begin
    o_sel = FWD_RF;
    if (w_live) begin
      if (i_wr_mem && (i_tgt_mem == i_src_reg)) begin
        o_sel = FWD_MEM;
      end else if (i_wr_wb && (i_tgt_wb == i_src_reg)) begin
        o_sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - EX operand forwarding with load-use and memory-wait stall control
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int NUM_SRC  = 3,
  parameter int REG_W    = 5,
  parameter int ZERO_REG = ZERO_REG_DEF,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_SRC-1:0]       src_valid_ID,
  input  logic [NUM_SRC*REG_W-1:0] src_reg_ID,
  input  logic [NUM_SRC-1:0]       src_valid_EX,
  input  logic [NUM_SRC*REG_W-1:0] src_reg_EX,
  input  logic                     RegWrite_EX,
  input  logic                     RegWrite_MEM,
  input  logic                     RegWrite_WB,
  input  logic [REG_W-1:0]         targetReg_EX,
  input  logic [REG_W-1:0]         targetReg_MEM,
  input  logic [REG_W-1:0]         targetReg_WB,
  input  logic                     MemRead_EX,
  input  logic                     MemRead_MEM,
  input  logic                     mem_ready,
  output logic [NUM_SRC*2-1:0]     fwd_sel,
  output logic                     stall,
  output logic                     bubble,
  output logic                     freeze,
  output logic [CNT_W-1:0]         stall_cycles
);

  localparam int               CW       = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
  localparam bit               HAS_WAIT = (LOAD_LAT > 1);
  localparam logic [CW-1:0]    CNT_LOAD = CW'(LOAD_LAT - 1);
  localparam logic [REG_W-1:0] ZR       = REG_W'(ZERO_REG);

  fsm_state_t       r_state;
  fsm_state_t       r_saved;
  logic [CW-1:0]    r_cnt;
  logic [CNT_W-1:0] r_stall_cycles;

  fsm_state_t w_eff_state;
  logic       w_mem_wait;
  logic       w_load_use;
  logic       w_hazard;
  logic       w_load_stall;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      fwd_operand_cmp #(
        .REG_W    (REG_W),
        .ZERO_REG (ZERO_REG)
      ) u_cmp (
        .i_src_valid (src_valid_EX[gi]),
        .i_src_reg   (src_reg_EX[gi*REG_W +: REG_W]),
        .i_wr_mem    (RegWrite_MEM),
        .i_tgt_mem   (targetReg_MEM),
        .i_wr_wb     (RegWrite_WB),
        .i_tgt_wb    (targetReg_WB),
        .o_sel       (fwd_sel[gi*2 +: 2])
      );
    end
  endgenerate

  always_comb begin
    w_load_use = 1'b0;
    if (MemRead_EX && RegWrite_EX && (targetReg_EX != ZR)) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (src_valid_ID[i] && (src_reg_ID[i*REG_W +: REG_W] == targetReg_EX)) begin
          w_load_use = 1'b1;
        end
      end
    end
  end

  assign w_mem_wait = MemRead_MEM && !mem_ready;
  assign w_hazard   = w_load_use && !w_mem_wait;

  // Once the memory completes, MEM_WAIT is transparent: the saved state acts in that same cycle.
  assign w_eff_state = ((r_state == MEM_WAIT) && !w_mem_wait) ? r_saved : r_state;

  assign w_load_stall = (w_eff_state == LOAD_WAIT) || ((w_eff_state == RUN) && w_hazard);

  assign freeze       = reset_n && w_mem_wait;
  assign stall        = reset_n && (w_mem_wait || w_load_stall);
  assign bubble       = reset_n && !w_mem_wait && w_load_stall;
  assign stall_cycles = r_stall_cycles;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state        <= RUN;
      r_saved        <= RUN;
      r_cnt          <= '0;
      r_stall_cycles <= '0;
    end else begin
      if (w_mem_wait) begin
        if (r_state != MEM_WAIT) begin
          r_saved <= r_state;
        end
        r_state <= MEM_WAIT;
      end else begin
        case (w_eff_state)
          RUN: begin
            if (w_hazard) begin
              r_cnt   <= CNT_LOAD;
              r_state <= HAS_WAIT ? LOAD_WAIT : RUN;
            end else begin
              r_state <= RUN;
            end
          end
          LOAD_WAIT: begin
            r_cnt   <= r_cnt - CW'(1);
            r_state <= (r_cnt <= CW'(1)) ? RUN : LOAD_WAIT;
          end
          default: r_state <= RUN;
        endcase
      end
      if (stall && (r_stall_cycles != {CNT_W{1'b1}})) begin
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - self-checking bench for fwd_hazard_unit
module tb_fwd_hazard_unit;

  localparam int NS = 3;
  localparam int RW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n;
  logic [NS-1:0]    src_valid_ID, src_valid_EX;
  logic [NS*RW-1:0] src_reg_ID, src_reg_EX;
  logic             RegWrite_EX, RegWrite_MEM, RegWrite_WB;
  logic [RW-1:0]    targetReg_EX, targetReg_MEM, targetReg_WB;
  logic             MemRead_EX, MemRead_MEM, mem_ready;

  logic [NS*2-1:0]  fwd_a, fwd_b;
  logic             stall_a, bubble_a, freeze_a;
  logic             stall_b, bubble_b, freeze_b;
  logic [15:0]      sc_a;
  logic [3:0]       sc_b;

  int checks = 0;
  int errors = 0;

  int     lat[2]  = '{1, 3};
  longint cmax[2] = '{65535, 15};
  int     rem[2]  = '{0, 0};
  longint cnt[2]  = '{0, 0};

  fwd_hazard_unit #(.NUM_SRC(NS), .REG_W(RW), .ZERO_REG(31), .LOAD_LAT(1), .CNT_W(16)) u_a (
    .clk(clk), .reset_n(reset_n),
    .src_valid_ID(src_valid_ID), .src_reg_ID(src_reg_ID),
    .src_valid_EX(src_valid_EX), .src_reg_EX(src_reg_EX),
    .RegWrite_EX(RegWrite_EX), .RegWrite_MEM(RegWrite_MEM), .RegWrite_WB(RegWrite_WB),
    .targetReg_EX(targetReg_EX), .targetReg_MEM(targetReg_MEM), .targetReg_WB(targetReg_WB),
    .MemRead_EX(MemRead_EX), .MemRead_MEM(MemRead_MEM), .mem_ready(mem_ready),
    .fwd_sel(fwd_a), .stall(stall_a), .bubble(bubble_a), .freeze(freeze_a),
    .stall_cycles(sc_a)
  );

  fwd_hazard_unit #(.NUM_SRC(NS), .REG_W(RW), .ZERO_REG(31), .LOAD_LAT(3), .CNT_W(4)) u_b (
    .clk(clk), .reset_n(reset_n),
    .src_valid_ID(src_valid_ID), .src_reg_ID(src_reg_ID),
    .src_valid_EX(src_valid_EX), .src_reg_EX(src_reg_EX),
    .RegWrite_EX(RegWrite_EX), .RegWrite_MEM(RegWrite_MEM), .RegWrite_WB(RegWrite_WB),
    .targetReg_EX(targetReg_EX), .targetReg_MEM(targetReg_MEM), .targetReg_WB(targetReg_WB),
    .MemRead_EX(MemRead_EX), .MemRead_MEM(MemRead_MEM), .mem_ready(mem_ready),
    .fwd_sel(fwd_b), .stall(stall_b), .bubble(bubble_b), .freeze(freeze_b),
    .stall_cycles(sc_b)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] exp_fwd(input int i);
    logic [RW-1:0] s;
    s = src_reg_EX[i*RW +: RW];
    if (!src_valid_EX[i] || s == 5'd31) return 2'b00;
    if (RegWrite_MEM && targetReg_MEM == s) return 2'b10;
    if (RegWrite_WB && targetReg_WB == s) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit load_use();
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < NS; i++)
      if (src_valid_ID[i] && src_reg_ID[i*RW +: RW] == targetReg_EX) hit = 1'b1;
    return MemRead_EX && RegWrite_EX && targetReg_EX != 5'd31 && hit;
  endfunction

  // One clock: check every output against the model at negedge, then advance the model.
  task automatic step();
    bit     e_st, e_bu, e_fr, mw, haz;
    int     n_rem[2];
    longint n_cnt[2];
    @(negedge clk);
    mw  = MemRead_MEM && !mem_ready;
    haz = load_use();
    for (int k = 0; k < 2; k++) begin
      e_st = 0; e_bu = 0; e_fr = 0;
      n_rem[k] = 0; n_cnt[k] = 0;
      if (reset_n) begin
        if (mw) begin
          e_fr = 1; e_st = 1; n_rem[k] = rem[k];
        end else if (rem[k] > 0) begin
          e_st = 1; e_bu = 1; n_rem[k] = rem[k] - 1;
        end else if (haz) begin
          e_st = 1; e_bu = 1; n_rem[k] = lat[k] - 1;
        end
        n_cnt[k] = (e_st && cnt[k] < cmax[k]) ? cnt[k] + 1 : cnt[k];
      end
      chk(k == 0 ? "m_stall_a"  : "m_stall_b",  k == 0 ? stall_a  : stall_b,  e_st);
      chk(k == 0 ? "m_bubble_a" : "m_bubble_b", k == 0 ? bubble_a : bubble_b, e_bu);
      chk(k == 0 ? "m_freeze_a" : "m_freeze_b", k == 0 ? freeze_a : freeze_b, e_fr);
      chk(k == 0 ? "m_cnt_a"    : "m_cnt_b",    k == 0 ? longint'(sc_a) : longint'(sc_b), cnt[k]);
    end
    for (int i = 0; i < NS; i++) begin
      chk("m_fwd_a", fwd_a[i*2 +: 2], exp_fwd(i));
      chk("m_fwd_b", fwd_b[i*2 +: 2], exp_fwd(i));
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      rem[k] = n_rem[k];
      cnt[k] = n_cnt[k];
    end
    #1;
  endtask

  task automatic clear_inputs();
    src_valid_ID = '0; src_reg_ID = '0; src_valid_EX = '0; src_reg_EX = '0;
    RegWrite_EX = 0; RegWrite_MEM = 0; RegWrite_WB = 0;
    targetReg_EX = '0; targetReg_MEM = '0; targetReg_WB = '0;
    MemRead_EX = 0; MemRead_MEM = 0; mem_ready = 1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 0;
    step();
    step();
    reset_n = 1;
  endtask

  function automatic logic [RW-1:0] rnd_reg();
    int r;
    r = $urandom_range(0, 5);
    return (r == 5) ? 5'd31 : RW'(r);
  endfunction

  initial begin
    reset_n = 0;
    clear_inputs();
    #1;
    do_reset();
    chk("rst_stall", stall_a, 0);
    chk("rst_cnt", sc_a, 0);

    // Forwarding priority and XZR
    RegWrite_MEM = 1; targetReg_MEM = 22; RegWrite_WB = 1; targetReg_WB = 22;
    src_valid_EX = 3'b001; src_reg_EX[0 +: RW] = 22;
    #2 chk("fwd_mem", fwd_a[1:0], 2'b10);
    step();
    RegWrite_MEM = 0;
    #2 chk("fwd_wb", fwd_a[1:0], 2'b01);
    step();
    RegWrite_MEM = 1; targetReg_MEM = 31; targetReg_WB = 31; src_reg_EX[0 +: RW] = 31;
    #2 chk("fwd_xzr", fwd_a[1:0], 2'b00);
    step();

    // Store-data operand
    clear_inputs();
    src_reg_EX[2*RW +: RW] = 5; targetReg_WB = 5; RegWrite_WB = 1; src_valid_EX = 3'b100;
    #2 chk("fwd_stur", fwd_a[5:4], 2'b01);
    step();
    src_valid_EX = 3'b000;
    #2 chk("fwd_stur_inv", fwd_a[5:4], 2'b00);
    step();

    // Load-use stall, LOAD_LAT 1 and 3
    do_reset();
    MemRead_EX = 1; RegWrite_EX = 1; targetReg_EX = 9;
    src_valid_ID = 3'b001; src_reg_ID[0 +: RW] = 9;
    #2 chk("lu_stall_a", stall_a, 1);
    chk("lu_bubble_a", bubble_a, 1);
    chk("lu_stall_b", stall_b, 1);
    step();
    MemRead_EX = 0;
    #2 chk("lu_end_a", stall_a, 0);
    chk("lu_cnt_a", sc_a, 1);
    chk("lu_hold_b1", stall_b, 1);
    step();
    #2 chk("lu_hold_b2", stall_b, 1);
    step();
    #2 chk("lu_end_b", stall_b, 0);
    chk("lu_cnt_b", sc_b, 3);
    step();

    // Memory wait of 4 cycles
    do_reset();
    MemRead_MEM = 1; mem_ready = 0;
    for (int c = 0; c < 4; c++) begin
      #2 chk("mw_freeze", freeze_a, 1);
      chk("mw_bubble", bubble_a, 0);
      step();
    end
    mem_ready = 1;
    #2 chk("mw_release", freeze_a, 0);
    chk("mw_rel_stall", stall_a, 0);
    chk("mw_cnt", sc_a, 4);
    step();
    MemRead_MEM = 0;

    // Load-use together with memory wait
    do_reset();
    MemRead_EX = 1; RegWrite_EX = 1; targetReg_EX = 9;
    src_valid_ID = 3'b010; src_reg_ID[RW +: RW] = 9;
    MemRead_MEM = 1; mem_ready = 0;
    for (int c = 0; c < 2; c++) begin
      #2 chk("both_freeze", freeze_a, 1);
      chk("both_bubble", bubble_b, 0);
      step();
    end
    mem_ready = 1;
    #2 chk("both_rel_fr", freeze_a, 0);
    chk("both_rel_bu", bubble_a, 1);
    chk("both_rel_st_b", stall_b, 1);
    step();
    MemRead_EX = 0; MemRead_MEM = 0;
    #2 chk("both_end_a", stall_a, 0);
    chk("both_cnt_a", sc_a, 3);
    chk("both_hold_b", stall_b, 1);
    step();
    step();
    #2 chk("both_end_b", stall_b, 0);
    chk("both_cnt_b", sc_b, 5);
    step();

    // Saturation and reset mid-MEM_WAIT
    do_reset();
    MemRead_MEM = 1; mem_ready = 0;
    for (int c = 0; c < 20; c++) step();
    chk("sat_cnt_b", sc_b, 15);
    chk("sat_cnt_a", sc_a, 20);
    reset_n = 0;
    #2 chk("rst_mw_stall", stall_a, 0);
    chk("rst_mw_freeze", freeze_b, 0);
    chk("rst_mw_bubble", bubble_b, 0);
    step();
    #2 chk("rst_mw_cnt_a", sc_a, 0);
    chk("rst_mw_cnt_b", sc_b, 0);
    clear_inputs();
    reset_n = 1;
    step();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      reset_n      = ($urandom_range(0, 60) != 0);
      src_valid_ID = NS'($urandom);
      src_valid_EX = NS'($urandom);
      for (int i = 0; i < NS; i++) begin
        src_reg_ID[i*RW +: RW] = rnd_reg();
        src_reg_EX[i*RW +: RW] = rnd_reg();
      end
      RegWrite_EX   = $urandom_range(0, 1);
      RegWrite_MEM  = $urandom_range(0, 1);
      RegWrite_WB   = $urandom_range(0, 1);
      targetReg_EX  = rnd_reg();
      targetReg_MEM = rnd_reg();
      targetReg_WB  = rnd_reg();
      MemRead_EX    = $urandom_range(0, 1);
      MemRead_MEM   = ($urandom_range(0, 2) == 0);
      mem_ready     = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised next-generation forwarding unit for the 5-stage ARM pipeline.
- Merges the EX-stage operand-forwarding muxes with load-use hazard detection and a multi-cycle memory-wait stall FSM.
- Sits between the ID/EX, EX/MEM and MEM/WB pipeline registers. Drives the EX operand-mux selects and the pipeline stall/bubble/freeze controls.
- Handles N source operands per instruction, so the STUR store-data operand is just another source. Counts stall cycles for performance visibility.

Parameters:
- NUM_SRC, 3, number of source operands checked per instruction (0=Rn, 1=Rm, 2=store data Rt).
- REG_W, 5, register index width.
- ZERO_REG, 31, register index that is never forwarded or hazarded (XZR).
- LOAD_LAT, 1, cycles after a load enters MEM before its data is forwardable from EX/MEM; minimum 1.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  pipeline clock.
- reset_n  in  1  synchronous, active-low reset.
- src_valid_ID  in  NUM_SRC  per-operand "reads a register" flags, decode stage.
- src_reg_ID  in  NUM_SRC*REG_W  source indices, decode stage; operand i is at [i*REG_W +: REG_W].
- src_valid_EX  in  NUM_SRC  per-operand read flags, EX stage.
- src_reg_EX  in  NUM_SRC*REG_W  source indices, EX stage.
- RegWrite_EX, RegWrite_MEM, RegWrite_WB  in  1 each  stage writes a register.
- targetReg_EX, targetReg_MEM, targetReg_WB  in  REG_W each  destination index per stage.
- MemRead_EX, MemRead_MEM  in  1 each  stage holds a load.
- mem_ready  in  1  data memory has completed the MEM-stage access.
- fwd_sel  out  NUM_SRC*2  per-operand select: 00 register file, 01 MEM/WB, 10 EX/MEM, 11 reserved.
- stall  out  1  hold PC and IF/ID.
- bubble  out  1  load NOP into ID/EX.
- freeze  out  1  hold every pipeline register.
- stall_cycles  out  CNT_W  saturating count of cycles with stall or freeze high.

Behaviour:
- Forwarding is combinational from the current inputs. For each operand i with src_valid_EX[i]=1 and src_reg_EX[i]!=ZERO_REG:
  - select 10 if RegWrite_MEM && targetReg_MEM==src_reg_EX[i];
  - else select 01 if RegWrite_WB && targetReg_WB==src_reg_EX[i];
  - else select 00.
- Operands with src_valid_EX[i]=0 select 00. EX/MEM always has priority over MEM/WB. A destination of ZERO_REG never matches.
- A load-use hazard exists when MemRead_EX && RegWrite_EX && targetReg_EX!=ZERO_REG and any valid ID operand equals targetReg_EX.
- FSM states:
  - RUN → LOAD_WAIT on a load-use hazard; counter loads LOAD_LAT-1. In that first cycle stall=1 and bubble=1 (combinational from the hazard).
  - LOAD_WAIT: stall=1, bubble=1; counter decrements each cycle; return to RUN when the counter is 0.
  - With LOAD_LAT=1, LOAD_WAIT lasts 0 extra cycles, so the total is one stall cycle.
  - Any state → MEM_WAIT when MemRead_MEM && !mem_ready. MEM_WAIT: freeze=1, stall=1, bubble=0. Return to the saved prior state (RUN or LOAD_WAIT, counter held) on the cycle mem_ready=1; freeze drops in that same cycle.
  - freeze has priority over bubble. The load-use check is suppressed while freeze=1 because the pipe does not advance.
  - A load-use hazard and a memory wait in the same cycle → MEM_WAIT; the hazard is re-evaluated after the memory wait.
- stall_cycles increments by 1 on every cycle with stall|freeze, and saturates at all-ones (no wrap).
- Reset (reset_n=0 on a clock edge):
  - state=RUN, counter=0, stall_cycles=0;
  - stall, bubble and freeze are forced 0 while reset_n=0, including when reset is asserted mid-MEM_WAIT or mid-LOAD_WAIT;
  - fwd_sel stays combinational.
- No forward from EX/MEM when MEM holds a load whose data is not yet ready; the FSM guarantees EX is frozen in that case.

Decomposition:
- Shared package: fwd_sel encoding constants (FWD_RF, FWD_WB, FWD_MEM), FSM state enum (RUN, LOAD_WAIT, MEM_WAIT), ZERO_REG default.
- Natural sub-module: fwd_operand_cmp, the per-operand priority comparator, instantiated NUM_SRC times with a generate loop.

Test Plan:
1. MEM writes X22, WB writes X22, EX Rn=X22 → fwd_sel[1:0]=10. Clear RegWrite_MEM → 01. Set targetReg_MEM=targetReg_WB=31 with Rn=31 → 00.
2. STUR operand 2 = X5, targetReg_WB=5, RegWrite_WB=1, src_valid_EX[2]=1 → fwd_sel[5:4]=01. Drop src_valid_EX[2] → 00.
3. LDUR X9 in EX, ADD in ID reading X9, LOAD_LAT=1 → stall=1 and bubble=1 for exactly 1 cycle; stall_cycles goes 0→1. Repeat with LOAD_LAT=3 → 3 stall cycles.
4. MemRead_MEM=1, mem_ready low for 4 cycles → freeze=1 for 4 cycles, bubble=0; freeze low in the cycle mem_ready rises; stall_cycles += 4.
5. Load-use hazard and memory wait raised in the same cycle → MEM_WAIT first, then the load-use stall after mem_ready; total stall count = wait + LOAD_LAT.
6. Assert reset_n=0 mid-MEM_WAIT → next edge stall=bubble=freeze=0 and stall_cycles=0; with CNT_W=4 and 20 stall cycles → stall_cycles holds 15.
